// File: rtl/rope_pkg.sv
// Shared types and constants for the rope-riding player controller.
package rope_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        GRAB     = 2'd1,
        RIDING   = 2'd2,
        COOLDOWN = 2'd3
    } rope_state_t;

    function automatic logic signed [11:0] clamp_offset(input logic signed [11:0] v,
                                                        input int max_v);
        if (int'(v) < 0)
            return 12'sd0;
        else if (int'(v) > max_v)
            return 12'(max_v);
        else
            return v;
    endfunction

endpackage

// File: rtl/rope_rider_ctrl.sv
// Player/rope attachment controller: grabs the rope on collision + up, rides it
// in x64 fixed point, climbs with up/down, releases on jump with a regrab cooldown.
module rope_rider_ctrl
    import rope_pkg::*;
#(
    parameter int CLIMB_SPEED   = 2,
    parameter int ROPE_LENGTH   = 200,
    parameter int REGRAB_FRAMES = 15
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               ropeCollision,
    input  logic               keyUp,
    input  logic               keyDown,
    input  logic               keyJump,
    input  logic signed [31:0] ropeSpeed,
    input  logic signed [10:0] ropeTopLeftX,
    input  logic signed [10:0] ropeTopLeftY,
    input  logic signed [10:0] playerX_in,
    input  logic signed [10:0] playerY_in,
    output logic signed [10:0] riderX,
    output logic signed [10:0] riderY,
    output logic               attached,
    output logic               releasePulse
);

    // state    | meaning
    // FREE     | player moves freely, waiting for collision + up
    // GRAB     | grip taken this frame, position snapped to rope
    // RIDING   | player follows rope, climbs with up/down
    // COOLDOWN | released, regrab blocked for REGRAB_FRAMES frames

    rope_state_t        state;
    logic signed [31:0] rider_x_fp;
    logic signed [11:0] offset_y;
    logic [15:0]        counter;
    logic               hit_latch;

    logic signed [31:0] rope_x_fp;
    logic signed [11:0] grab_offset;
    logic signed [11:0] climbed;

    assign rope_x_fp   = int'(ropeTopLeftX) * FIXED_POINT_MULTIPLIER;
    assign grab_offset = clamp_offset(12'(playerY_in) - 12'(ropeTopLeftY), ROPE_LENGTH);

    always_comb begin
        climbed = offset_y;
        if (keyUp && !keyDown)
            climbed = (int'(offset_y) < CLIMB_SPEED) ? 12'sd0 : offset_y - 12'(CLIMB_SPEED);
        else if (keyDown && !keyUp)
            climbed = (int'(offset_y) > ROPE_LENGTH - CLIMB_SPEED) ? 12'(ROPE_LENGTH)
                                                                   : offset_y + 12'(CLIMB_SPEED);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= FREE;
            rider_x_fp   <= '0;
            offset_y     <= '0;
            counter      <= '0;
            hit_latch    <= 1'b0;
            attached     <= 1'b0;
            releasePulse <= 1'b0;
        end else begin
            releasePulse <= 1'b0;
            if (startOfFrame)
                hit_latch <= 1'b0;
            else if (ropeCollision)
                hit_latch <= 1'b1;

            if (startOfFrame) begin
                unique case (state)
                    FREE: begin
                        // Snap on entry too, so GRAB already shows the rope position.
                        if (hit_latch && keyUp) begin
                            state      <= GRAB;
                            attached   <= 1'b1;
                            rider_x_fp <= rope_x_fp;
                            offset_y   <= grab_offset;
                        end
                    end
                    GRAB: begin
                        state      <= RIDING;
                        rider_x_fp <= rope_x_fp;
                        offset_y   <= grab_offset;
                    end
                    RIDING: begin
                        if (keyJump) begin
                            state        <= COOLDOWN;
                            attached     <= 1'b0;
                            releasePulse <= 1'b1;
                            counter      <= 16'(REGRAB_FRAMES);
                        end else begin
                            rider_x_fp <= rider_x_fp + ropeSpeed;
                            offset_y   <= climbed;
                        end
                    end
                    COOLDOWN: begin
                        if (counter <= 16'd1) begin
                            counter <= '0;
                            state   <= FREE;
                        end else begin
                            counter <= counter - 16'd1;
                        end
                    end
                    default: state <= FREE;
                endcase
            end
        end
    end

    assign riderX = attached ? 11'(rider_x_fp / FIXED_POINT_MULTIPLIER) : playerX_in;
    assign riderY = attached ? 11'(12'(ropeTopLeftY) + offset_y) : playerY_in;

endmodule

// File: tb/tb_rope_rider_ctrl.sv
// Self-checking bench for rope_rider_ctrl: frame-level behavioural model checked
// every cycle, plus hand-computed expectations at key points.
module tb_rope_rider_ctrl;

    localparam int CLIMB  = 2;
    localparam int LENGTH = 200;
    localparam int REGRAB = 15;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               ropeCollision = 1'b0;
    logic               keyUp = 1'b0, keyDown = 1'b0, keyJump = 1'b0;
    logic signed [31:0] ropeSpeed = 32'sd0;
    logic signed [10:0] ropeTopLeftX = 11'sd280, ropeTopLeftY = 11'sd100;
    logic signed [10:0] playerX_in = 11'sd37, playerY_in = 11'sd150;
    logic signed [10:0] riderX, riderY;
    logic               attached, releasePulse;

    int tests = 0;
    int fails = 0;

    rope_rider_ctrl #(
        .CLIMB_SPEED  (CLIMB),
        .ROPE_LENGTH  (LENGTH),
        .REGRAB_FRAMES(REGRAB)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .ropeCollision(ropeCollision),
        .keyUp        (keyUp),
        .keyDown      (keyDown),
        .keyJump      (keyJump),
        .ropeSpeed    (ropeSpeed),
        .ropeTopLeftX (ropeTopLeftX),
        .ropeTopLeftY (ropeTopLeftY),
        .playerX_in   (playerX_in),
        .playerY_in   (playerY_in),
        .riderX       (riderX),
        .riderY       (riderY),
        .attached     (attached),
        .releasePulse (releasePulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level model: holding flag, first-frame flag, cooldown frame count.
    bit     m_hold = 0, m_first = 0, m_cool = 0, m_rel = 0, m_hit = 0;
    longint m_x = 0;
    int     m_off = 0, m_since = 0;

    function automatic int grip_offset();
        int d = int'(playerY_in) - int'(ropeTopLeftY);
        if (d < 0) d = 0;
        if (d > LENGTH) d = LENGTH;
        return d;
    endfunction

    always @(posedge clk or negedge resetN) begin
        bit     hold, first, cool, rel, hit;
        longint x;
        int     off, since;
        if (!resetN) begin
            m_hold <= 0; m_first <= 0; m_cool <= 0; m_rel <= 0; m_hit <= 0;
            m_x <= 0; m_off <= 0; m_since <= 0;
        end else begin
            hold = m_hold; first = m_first; cool = m_cool; hit = m_hit;
            x = m_x; off = m_off; since = m_since; rel = 0;
            if (startOfFrame) begin
                if (cool) begin
                    since = since + 1;
                    if (since >= REGRAB) cool = 0;
                end else if (hold && first) begin
                    first = 0;
                    x = longint'(ropeTopLeftX) * 64;
                    off = grip_offset();
                end else if (hold) begin
                    if (keyJump) begin
                        hold = 0; rel = 1; cool = 1; since = 0;
                    end else begin
                        x = x + longint'(ropeSpeed);
                        if (keyUp && !keyDown) off = (off - CLIMB < 0) ? 0 : off - CLIMB;
                        if (keyDown && !keyUp) off = (off + CLIMB > LENGTH) ? LENGTH : off + CLIMB;
                    end
                end else if (hit && keyUp) begin
                    hold = 1; first = 1;
                    x = longint'(ropeTopLeftX) * 64;
                    off = grip_offset();
                end
                hit = 0;
            end else if (ropeCollision) begin
                hit = 1;
            end
            m_hold <= hold; m_first <= first; m_cool <= cool; m_rel <= rel; m_hit <= hit;
            m_x <= x; m_off <= off; m_since <= since;
        end
    end

    always @(negedge clk) begin
        if (resetN) begin
            chk("cyc_attached", int'(attached), int'(m_hold));
            chk("cyc_releasePulse", int'(releasePulse), int'(m_rel));
            chk("cyc_riderX", int'(riderX),
                m_hold ? int'(m_x / 64) : int'(playerX_in));
            chk("cyc_riderY", int'(riderY),
                m_hold ? int'(ropeTopLeftY) + m_off : int'(playerY_in));
        end
    end

    // One frame: keys held throughout, optional collision pulse mid-frame,
    // startOfFrame sampled on the last edge; returns 1 time unit after that edge.
    task automatic frame(input bit col, input bit up, input bit dn, input bit jmp);
        @(posedge clk); #1 keyUp = up; keyDown = dn; keyJump = jmp;
        @(posedge clk); #1 ropeCollision = col;
        @(posedge clk); #1 ropeCollision = 1'b0;
        @(posedge clk); #1 startOfFrame = 1'b1;
        @(posedge clk); #1 startOfFrame = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_attached", int'(attached), 0);
        chk("rst_release", int'(releasePulse), 0);
        chk("rst_riderX", int'(riderX), 37);
        chk("rst_riderY", int'(riderY), 150);
        resetN = 1'b1;

        frame(1, 1, 0, 0);
        chk("grab_attached", int'(attached), 1);
        frame(0, 0, 0, 0);
        chk("ride_riderX", int'(riderX), 280);
        chk("ride_riderY", int'(riderY), 150);
        chk("ride_attached", int'(attached), 1);

        ropeSpeed = 32'sd30;
        repeat (64) frame(0, 0, 0, 0);
        chk("speed_pos64", int'(riderX), 310);
        ropeSpeed = -32'sd30;
        repeat (64) frame(0, 0, 0, 0);
        chk("speed_back", int'(riderX), 280);
        frame(0, 0, 0, 0);
        chk("speed_trunc", int'(riderX), 279);
        ropeSpeed = 32'sd0;

        frame(0, 1, 0, 1);
        chk("jump_release", int'(releasePulse), 1);
        chk("jump_attached", int'(attached), 0);
        chk("jump_riderX", int'(riderX), 37);
        @(posedge clk); #1;
        chk("jump_release_one", int'(releasePulse), 0);

        for (int i = 1; i <= REGRAB; i++) begin
            frame(1, 1, 0, 0);
            chk($sformatf("cool_ignore_%0d", i), int'(attached), 0);
        end
        playerY_in = 11'sd101;
        frame(1, 1, 0, 0);
        chk("regrab_16", int'(attached), 1);
        frame(0, 0, 0, 0);
        chk("off1_riderY", int'(riderY), 101);
        repeat (2) frame(0, 1, 0, 0);
        chk("floor_riderY", int'(riderY), 100);

        playerX_in = 11'sd55;
        @(posedge clk); #2 resetN = 1'b0;
        #1;
        chk("midrst_attached", int'(attached), 0);
        chk("midrst_riderX", int'(riderX), 55);
        chk("midrst_release", int'(releasePulse), 0);
        @(posedge clk); #1 resetN = 1'b1;

        playerY_in = 11'sd299;
        frame(1, 1, 0, 0);
        chk("grab2_attached", int'(attached), 1);
        frame(0, 0, 0, 0);
        chk("off199_riderY", int'(riderY), 299);
        repeat (2) frame(0, 0, 1, 0);
        chk("ceil_riderY", int'(riderY), 300);
        frame(0, 1, 0, 0);
        chk("up_riderY", int'(riderY), 298);
        frame(0, 1, 1, 0);
        chk("both_riderY", int'(riderY), 298);

        frame(0, 0, 0, 1);
        chk("jump2_release", int'(releasePulse), 1);
        repeat (REGRAB) frame(0, 0, 0, 0);
        frame(1, 0, 0, 0);
        chk("nokey_free", int'(attached), 0);
        frame(0, 1, 0, 0);
        chk("hit_cleared", int'(attached), 0);

        playerY_in = 11'sd80;
        frame(1, 1, 0, 0);
        frame(0, 0, 0, 0);
        chk("clamp_low_riderY", int'(riderY), 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rope_rider_ctrl.md
ROPE_RIDER_CTRL -- requirements
Module: rope_rider_ctrl

Interface
REQ-001 SHALL have parameter CLIMB_SPEED, default 2, rope climb/descend step in pixels per frame.
REQ-002 SHALL have parameter ROPE_LENGTH, default 200, maximum grip offset below rope top, in pixels.
REQ-003 SHALL have parameter REGRAB_FRAMES, default 15, frames before the player may grab again after release.
REQ-004 clk  in  1  system clock.
REQ-005 resetN  in  1  reset, asynchronous, active-low.
REQ-006 startOfFrame  in  1  one-clk pulse per frame (30 Hz).
REQ-007 ropeCollision  in  1  player/rope pixel overlap, asserted during drawing.
REQ-008 keyUp, keyDown, keyJump  in  1 each  level key states.
REQ-009 ropeSpeed  in  int (32, signed)  rope X speed, fixed point x64 per frame.
REQ-010 ropeTopLeftX, ropeTopLeftY  in  signed 11  rope position.
REQ-011 playerX_in, playerY_in  in  signed 11  free-movement player position.
REQ-012 riderX, riderY  out  signed 11  resolved player position.
REQ-013 attached  out  1  player is holding the rope.
REQ-014 releasePulse  out  1  one-clk pulse on leaving RIDING.

Function
REQ-015 SHALL latch ropeCollision into hitLatch on any clk; hitLatch SHALL clear on startOfFrame after being sampled.
REQ-016 SHALL have states FREE, GRAB, RIDING, COOLDOWN; all transitions occur only on startOfFrame.
REQ-017 FREE -> GRAB when hitLatch && keyUp; otherwise stay.
REQ-018 GRAB -> RIDING on next startOfFrame: riderX_fp = ropeTopLeftX*64; offsetY = playerY_in - ropeTopLeftY clamped to [0, ROPE_LENGTH].
REQ-019 RIDING per frame: riderX_fp += ropeSpeed (32-bit signed); keyUp alone: offsetY -= CLIMB_SPEED, floor 0; keyDown alone: offsetY += CLIMB_SPEED, ceiling ROPE_LENGTH; both or neither: no change.
REQ-020 RIDING with keyJump -> COOLDOWN; keyJump takes priority over keyUp/keyDown in the same frame; releasePulse high for the clk of the transition.
REQ-021 COOLDOWN loads counter = REGRAB_FRAMES on entry, decrements per startOfFrame, -> FREE when counter reaches 0; hitLatch ignored in COOLDOWN.
REQ-022 riderX = riderX_fp / 64, signed division truncating toward zero; riderY = ropeTopLeftY + offsetY; both in GRAB and RIDING.
REQ-023 In FREE and COOLDOWN, riderX/riderY SHALL equal playerX_in/playerY_in combinationally.
REQ-024 attached SHALL be 1 exactly in GRAB and RIDING, registered with the state.
REQ-025 ropeSpeed sign changes mid-ride take effect on the next frame with no extra latency.

Reset
REQ-026 On resetN low, asynchronously: state FREE, riderX_fp 0, offsetY 0, counter 0, hitLatch 0, releasePulse 0, attached 0.
REQ-027 Reset mid-ride SHALL drop the grip immediately without a releasePulse; outputs follow the player-position pass-through.

Structure
REQ-028 FIXED_POINT_MULTIPLIER (64) and the state enum SHALL live in the shared package rope_pkg.
REQ-029 Single module; no sub-module; cooldown counter and hitLatch inline.

Verification
REQ-030 playerY_in=150, ropeTopLeftY=100, ropeTopLeftX=280, collision plus keyUp in frame 1 -> GRAB at frame 1, RIDING at frame 2 with riderX=280, riderY=150, attached=1.
REQ-031 RIDING with ropeSpeed=30 for 64 frames -> riderX advances by 30 pixels; ropeSpeed=-30 from 280 for 1 frame -> riderX=279 (truncation toward zero).
REQ-032 RIDING, offsetY=1, keyUp held 2 frames -> offsetY 0; offsetY=199, keyDown held -> stays at 200.
REQ-033 keyJump plus keyUp in the same frame while RIDING -> COOLDOWN, releasePulse one clk, attached=0; collision plus keyUp during the next 15 frames ignored; grab is accepted at frame 16.
REQ-034 resetN low while RIDING -> state FREE at once, attached=0, riderX=playerX_in, no releasePulse.
REQ-035 Collision pulse mid-frame with keyUp released at startOfFrame -> stays FREE; hitLatch is cleared.
